instruction_uart_dump: RTL and testbench
========================================

Name: instruction_uart_dump

Overview:
- Read-back/transmit side of the instruction-load path.
- Walks the instruction RAM from address 0 in FIFO order using a 1-cycle synchronous read port.
- Serialises each non-zero byte onto a UART 8N1 line, followed by the '$' (0x24) delimiter, so the host receives the same framing it used when loading.
- Stops at the first zero byte or after address MAX_ADDRESS.

Parameters:
- N, 8: data and address width. The datapath is fixed at 8 bits; N must be 8.
- MAX_ADDRESS, 255: last RAM address that may be fetched.
- CLKS_PER_BIT, 434: clk cycles per UART bit (50 MHz / 115200). Must be 2 or more.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  level; sampled only in IDLE; begins a dump.
- ram_addr  output  N  read address to the instruction RAM.
- ram_data  input  N  RAM read data; valid 1 clk after ram_addr changes.
- tx  output  1  UART serial out; idles high.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse when a dump completes.
- byte_count  output  N+1  count of data bytes sent in the current/last dump. Delimiters are not counted.

Behaviour:
- Reset (rst low, asynchronous):
  - State goes to IDLE.
  - Outputs: tx=1, busy=0, done=0, ram_addr=0, byte_count=0.
  - Baud counter, bit index and shift register are cleared.
- Reset asserted mid-frame aborts the frame immediately: tx returns high with no stop bit.
- States: IDLE, FETCH, LOAD, START_BIT, DATA_BITS, STOP_BIT, DELIM_START, DELIM_BITS, DELIM_STOP, NEXT, DONE.
- IDLE:
  - If start=1: set ram_addr=0 and byte_count=0, then go to FETCH.
  - Otherwise hold.
- FETCH: one wait cycle for the RAM read latency, then go to LOAD.
- LOAD:
  - If ram_data==0, go to DONE. Zero is the end-of-program marker and is not transmitted.
  - Otherwise latch ram_data into the shift register, increment byte_count, and go to START_BIT.
- Frame format: tx driven low for CLKS_PER_BIT cycles (start bit), then 8 data bits LSB first, then tx high for CLKS_PER_BIT cycles (stop bit). One frame is 10*CLKS_PER_BIT cycles.
- Baud counter:
  - Counts 0..CLKS_PER_BIT-1.
  - The bit transitions when the counter reaches CLKS_PER_BIT-1.
  - The counter restarts at 0 at the start of every bit.
- After STOP_BIT, a delimiter frame carrying 0x24 is sent using the same timing. No idle gap is inserted between the data frame and the delimiter frame.
- A data byte equal to 0x24 is transmitted as-is. No escaping is done.
- NEXT:
  - If ram_addr==MAX_ADDRESS, go to DONE.
  - Otherwise ram_addr <= ram_addr+1 and go to FETCH.
  - ram_addr never wraps past MAX_ADDRESS.
- DONE:
  - done=1 for exactly one cycle, busy=0 from the next cycle, then go to IDLE.
  - ram_addr and byte_count hold their final values until the next start.
- start held high continuously re-triggers a new dump after DONE, restarting from address 0.
- start is ignored while busy.
- tx is registered (glitch-free); there is no combinational path from ram_data to tx.
- Latency from start sampled high to the tx falling edge of the first start bit: 3 clk (IDLE→FETCH→LOAD→START_BIT).

Test Plan:
- CLKS_PER_BIT=4; RAM contains 0x41, 0x42, 0x00; pulse start → tx carries frames 0x41, 0x24, 0x42, 0x24 (each 40 clk, back-to-back); one done pulse; byte_count=2; ram_addr=2.
- RAM[0]=0x00; start → no start bit ever appears on tx; done pulses 3 clk after start; byte_count=0.
- MAX_ADDRESS=3; RAM all 0x55 → exactly 4 data frames plus 4 delimiter frames; ram_addr stops at 3 with no wrap; byte_count=4.
- RAM[0]=0x24 (edge value) → two consecutive 0x24 frames; byte_count=1.
- rst pulled low midway through the 0x41 data bits → tx=1 and busy=0 immediately; after release, start → the dump restarts at ram_addr=0 with a complete 0x41 frame.
- start pulsed again during an active dump → no effect on sequence or timing; exactly one done pulse.

Source files
------------

// File: rtl/instruction_uart_dump.sv
// Read-back side of the instruction-load path: walks the instruction RAM from address 0
// and replays each non-zero byte as a UART 8N1 frame followed by a '$' delimiter frame.
module instruction_uart_dump #(
  parameter int N            = 8,
  parameter int MAX_ADDRESS  = 255,
  parameter int CLKS_PER_BIT = 434
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  output logic [N-1:0] ram_addr,
  input  logic [N-1:0] ram_data,
  output logic         tx,
  output logic         busy,
  output logic         done,
  output logic [N:0]   byte_count
);

  localparam int            CW        = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [N-1:0]  ADDR_LAST = N'(MAX_ADDRESS);
  localparam logic [7:0]    DELIM     = 8'h24;

  localparam logic [3:0] IDLE        = 4'd0;
  localparam logic [3:0] FETCH       = 4'd1;
  localparam logic [3:0] LOAD        = 4'd2;
  localparam logic [3:0] START_BIT   = 4'd3;
  localparam logic [3:0] DATA_BITS   = 4'd4;
  localparam logic [3:0] STOP_BIT    = 4'd5;
  localparam logic [3:0] DELIM_START = 4'd6;
  localparam logic [3:0] DELIM_BITS  = 4'd7;
  localparam logic [3:0] DELIM_STOP  = 4'd8;
  localparam logic [3:0] NEXT        = 4'd9;
  localparam logic [3:0] DONE        = 4'd10;

  logic [3:0]    state_r;
  logic [CW-1:0] baud_r;
  logic [2:0]    bit_idx_r;
  logic [7:0]    shift_r;
  logic          baud_last_s;

  assign baud_last_s = (baud_r == BAUD_LAST);

  // Dump sequencer; tx is driven only from registers so the line never glitches.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= IDLE;
      baud_r     <= '0;
      bit_idx_r  <= 3'd0;
      shift_r    <= 8'h00;
      ram_addr   <= '0;
      byte_count <= '0;
      tx         <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            ram_addr   <= '0;
            byte_count <= '0;
            busy       <= 1'b1;
            state_r    <= FETCH;
          end else begin
            busy <= 1'b0;
          end
        end
        FETCH: begin
          state_r <= LOAD;
        end
        LOAD: begin
          // A zero byte marks the end of the program and is never sent.
          if (ram_data == {N{1'b0}}) begin
            done    <= 1'b1;
            state_r <= DONE;
          end else begin
            shift_r    <= ram_data[7:0];
            byte_count <= byte_count + (N+1)'(1);
            baud_r     <= '0;
            tx         <= 1'b0;
            state_r    <= START_BIT;
          end
        end
        START_BIT, DELIM_START: begin
          if (baud_last_s) begin
            baud_r    <= '0;
            bit_idx_r <= 3'd0;
            tx        <= shift_r[0];
            state_r   <= (state_r == START_BIT) ? DATA_BITS : DELIM_BITS;
          end else begin
            baud_r <= baud_r + CW'(1);
          end
        end
        DATA_BITS, DELIM_BITS: begin
          if (baud_last_s) begin
            baud_r <= '0;
            if (bit_idx_r == 3'd7) begin
              tx      <= 1'b1;
              state_r <= (state_r == DATA_BITS) ? STOP_BIT : DELIM_STOP;
            end else begin
              bit_idx_r <= bit_idx_r + 3'd1;
              shift_r   <= {1'b0, shift_r[7:1]};
              tx        <= shift_r[1];
            end
          end else begin
            baud_r <= baud_r + CW'(1);
          end
        end
        STOP_BIT: begin
          // Delimiter frame follows the stop bit with no idle gap.
          if (baud_last_s) begin
            baud_r  <= '0;
            shift_r <= DELIM;
            tx      <= 1'b0;
            state_r <= DELIM_START;
          end else begin
            baud_r <= baud_r + CW'(1);
          end
        end
        DELIM_STOP: begin
          if (baud_last_s) begin
            baud_r  <= '0;
            state_r <= NEXT;
          end else begin
            baud_r <= baud_r + CW'(1);
          end
        end
        NEXT: begin
          if (ram_addr == ADDR_LAST) begin
            done    <= 1'b1;
            state_r <= DONE;
          end else begin
            ram_addr <= ram_addr + N'(1);
            state_r  <= FETCH;
          end
        end
        DONE: begin
          busy    <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          tx      <= 1'b1;
          busy    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_uart_dump.sv
// Self-checking bench for instruction_uart_dump: records tx per clock, decodes UART
// frames from the waveform and compares them with a model derived from RAM contents.
module tb_instruction_uart_dump;

  localparam int CPB    = 4;
  localparam int MAXA   = 3;
  localparam int BUDGET = 3000;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [7:0] ram_addr;
  logic [7:0] ram_data;
  logic       tx;
  logic       busy;
  logic       done;
  logic [8:0] byte_count;

  logic [7:0] mem [256];

  int n_checks = 0;
  int n_fail   = 0;

  logic       tx_q[$];
  int         done_idx[$];
  int         addr_max;
  int         timed_out;
  logic [127:0] obs_vec;
  logic [127:0] exp_vec;
  int         obs_pos [16];
  int         obs_n, frame_err, gap_bad;
  int         exp_n, exp_cnt, exp_addr;

  instruction_uart_dump #(.N(8), .MAX_ADDRESS(MAXA), .CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .ram_addr   (ram_addr),
    .ram_data   (ram_data),
    .tx         (tx),
    .busy       (busy),
    .done       (done),
    .byte_count (byte_count)
  );

  always #5 clk = ~clk;

  // Instruction RAM with a one-cycle synchronous read port.
  always @(posedge clk) ram_data <= mem[ram_addr];

  task automatic fill_mem(input logic [7:0] v);
    for (int a = 0; a < 256; a++) mem[a] = v;
  endtask

  // Expected frames: each non-zero byte then '$', stopping at a zero byte or after MAXA.
  task automatic model();
    exp_vec = '0; exp_n = 0; exp_cnt = 0; exp_addr = 0;
    for (int a = 0; a <= MAXA; a++) begin
      exp_addr = a;
      if (mem[a] == 8'h00) break;
      exp_vec[8*exp_n +: 8]   = mem[a];
      exp_vec[8*exp_n+8 +: 8] = 8'h24;
      exp_n   += 2;
      exp_cnt += 1;
    end
  endtask

  // UART receiver over the recorded waveform; every bit must be flat for CPB samples.
  task automatic decode();
    int i, prev;
    logic [9:0] b;
    obs_vec = '0; obs_n = 0; frame_err = 0; gap_bad = 0; prev = -1000;
    for (int k = 0; k < 16; k++) obs_pos[k] = -1;
    i = 1;
    while (i < tx_q.size()) begin
      if (tx_q[i] === 1'b0 && tx_q[i-1] === 1'b1) begin
        if (i + 10*CPB > tx_q.size()) begin
          frame_err++;
          break;
        end
        for (int k = 0; k < 10; k++) begin
          b[k] = tx_q[i + k*CPB];
          for (int j = 1; j < CPB; j++)
            if (tx_q[i + k*CPB + j] !== b[k]) frame_err++;
        end
        if (b[0] !== 1'b0 || b[9] !== 1'b1) frame_err++;
        if (obs_n < 16) begin
          obs_vec[8*obs_n +: 8] = b[8:1];
          obs_pos[obs_n] = i;
        end
        if ((obs_n % 2) == 1 && i != prev + 10*CPB) gap_bad++;
        prev = i;
        obs_n++;
        i += 10*CPB;
      end else begin
        i++;
      end
    end
  endtask

  // mode 0: single pulse; 1: extra pulses while busy; 2: hold start until two dumps done.
  task automatic run_dump(input int mode);
    int target, stop_at;
    tx_q.delete(); done_idx.delete(); addr_max = 0; timed_out = 0;
    target  = (mode == 2) ? 2 : 1;
    stop_at = -1;
    @(negedge clk);
    tx_q.push_back(tx);
    start = 1'b1;
    for (int c = 1; c <= BUDGET; c++) begin
      @(negedge clk);
      tx_q.push_back(tx);
      if (int'(ram_addr) > addr_max) addr_max = int'(ram_addr);
      if (done === 1'b1) done_idx.push_back(c);
      case (mode)
        1:       start = ((c >= 20 && c <= 25) || (c >= 100 && c <= 102));
        2:       start = (done_idx.size() < 2);
        default: start = 1'b0;
      endcase
      if (stop_at < 0 && done_idx.size() >= target) stop_at = c + 2;
      if (c == stop_at) break;
    end
    start = 1'b0;
    n_checks++;
    if (stop_at < 0) begin
      n_fail++;
      timed_out = 1;
      $display("FAIL dump_timeout: done pulses seen %0d, required %0d within %0d clk", done_idx.size(), target, BUDGET);
    end
    decode();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (tx !== 1'b1)          begin n_fail++; $display("FAIL reset_tx: got %b expected 1", tx); end
    n_checks++; if (busy !== 1'b0)        begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (done !== 1'b0)        begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
    n_checks++; if (ram_addr !== 8'h00)   begin n_fail++; $display("FAIL reset_addr: got %h expected 00", ram_addr); end
    n_checks++; if (byte_count !== 9'd0)  begin n_fail++; $display("FAIL reset_count: got %0d expected 0", byte_count); end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++; if (tx !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL idle_hold: tx %b busy %b expected 1 0", tx, busy); end
  endtask

  task automatic test_basic();
    fill_mem(8'h00); mem[0] = 8'h41; mem[1] = 8'h42;
    model();
    run_dump(0);
    n_checks++; if (obs_n !== 4)               begin n_fail++; $display("FAIL basic_nframes: got %0d expected 4", obs_n); end
    n_checks++; if (obs_vec[31:0] !== 32'h2442_2441) begin n_fail++; $display("FAIL basic_bytes: got %h expected 24422441", obs_vec[31:0]); end
    n_checks++; if (frame_err !== 0 || gap_bad !== 0) begin n_fail++; $display("FAIL basic_timing: frame_err %0d gap_bad %0d expected 0 0", frame_err, gap_bad); end
    n_checks++; if (obs_pos[0] !== 3)          begin n_fail++; $display("FAIL basic_latency: first start bit at %0d expected 3", obs_pos[0]); end
    n_checks++; if (done_idx.size() !== 1)     begin n_fail++; $display("FAIL basic_done: pulses %0d expected 1", done_idx.size()); end
    n_checks++; if (byte_count !== 9'd2)       begin n_fail++; $display("FAIL basic_count: got %0d expected 2", byte_count); end
    n_checks++; if (ram_addr !== 8'd2)         begin n_fail++; $display("FAIL basic_addr: got %0d expected 2", ram_addr); end
    n_checks++; if (busy !== 1'b0)             begin n_fail++; $display("FAIL basic_busy_after: got %b expected 0", busy); end
  endtask

  task automatic test_empty();
    fill_mem(8'h00); mem[1] = 8'h41;
    run_dump(0);
    n_checks++; if (obs_n !== 0)               begin n_fail++; $display("FAIL empty_frames: got %0d expected 0", obs_n); end
    n_checks++; if (done_idx.size() !== 1 || done_idx[0] !== 3) begin n_fail++; $display("FAIL empty_done: pulses %0d first at %0d expected 1 at 3", done_idx.size(), (done_idx.size() > 0) ? done_idx[0] : -1); end
    n_checks++; if (byte_count !== 9'd0)       begin n_fail++; $display("FAIL empty_count: got %0d expected 0", byte_count); end
    n_checks++; if (ram_addr !== 8'd0)         begin n_fail++; $display("FAIL empty_addr: got %0d expected 0", ram_addr); end
  endtask

  task automatic test_max_addr();
    fill_mem(8'h55);
    model();
    run_dump(0);
    n_checks++; if (obs_n !== 8 || obs_vec !== exp_vec) begin n_fail++; $display("FAIL max_frames: got %0d frames %h expected 8 frames %h", obs_n, obs_vec, exp_vec); end
    n_checks++; if (frame_err !== 0 || gap_bad !== 0) begin n_fail++; $display("FAIL max_timing: frame_err %0d gap_bad %0d expected 0 0", frame_err, gap_bad); end
    n_checks++; if (addr_max > MAXA)           begin n_fail++; $display("FAIL max_nowrap: highest addr %0d expected <= %0d", addr_max, MAXA); end
    n_checks++; if (ram_addr !== 8'd3)         begin n_fail++; $display("FAIL max_addr: got %0d expected 3", ram_addr); end
    n_checks++; if (byte_count !== 9'd4)       begin n_fail++; $display("FAIL max_count: got %0d expected 4", byte_count); end
    n_checks++; if (done_idx.size() !== 1)     begin n_fail++; $display("FAIL max_done: pulses %0d expected 1", done_idx.size()); end
  endtask

  task automatic test_delim_value();
    fill_mem(8'h00); mem[0] = 8'h24;
    run_dump(0);
    n_checks++; if (obs_n !== 2 || obs_vec[15:0] !== 16'h2424) begin n_fail++; $display("FAIL delim_frames: got %0d frames %h expected 2 frames 2424", obs_n, obs_vec[15:0]); end
    n_checks++; if (gap_bad !== 0 || frame_err !== 0) begin n_fail++; $display("FAIL delim_timing: frame_err %0d gap_bad %0d expected 0 0", frame_err, gap_bad); end
    n_checks++; if (byte_count !== 9'd1)       begin n_fail++; $display("FAIL delim_count: got %0d expected 1", byte_count); end
  endtask

  task automatic test_random();
    int len;
    for (int it = 0; it < 6; it++) begin
      len = $urandom_range(0, 4);
      for (int a = 0; a < 256; a++) mem[a] = 8'($urandom_range(1, 255));
      for (int a = len; a <= MAXA; a++) mem[a] = 8'h00;
      if (len > 0 && $urandom_range(0, 1) == 1) mem[0] = 8'h24;
      model();
      run_dump(0);
      n_checks++; if (obs_n !== exp_n || obs_vec !== exp_vec) begin n_fail++; $display("FAIL rand%0d_frames: got %0d frames %h expected %0d frames %h", it, obs_n, obs_vec, exp_n, exp_vec); end
      n_checks++; if (frame_err !== 0 || gap_bad !== 0) begin n_fail++; $display("FAIL rand%0d_timing: frame_err %0d gap_bad %0d expected 0 0", it, frame_err, gap_bad); end
      n_checks++; if (byte_count !== 9'(exp_cnt)) begin n_fail++; $display("FAIL rand%0d_count: got %0d expected %0d", it, byte_count, exp_cnt); end
      n_checks++; if (ram_addr !== 8'(exp_addr))  begin n_fail++; $display("FAIL rand%0d_addr: got %0d expected %0d", it, ram_addr, exp_addr); end
    end
  endtask

  task automatic test_reset_midframe();
    fill_mem(8'h00); mem[0] = 8'h41; mem[1] = 8'h42;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (11) @(negedge clk);
    // Sample 12 lies inside data bit 1 of 0x41, which is a zero.
    n_checks++; if (tx !== 1'b0)               begin n_fail++; $display("FAIL mid_pre_tx: got %b expected 0", tx); end
    #2 rst = 1'b0;
    #1;
    n_checks++; if (tx !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL mid_abort: tx %b busy %b expected 1 0", tx, busy); end
    n_checks++; if (byte_count !== 9'd0)       begin n_fail++; $display("FAIL mid_count: got %0d expected 0", byte_count); end
    @(negedge clk); rst = 1'b1;
    model();
    run_dump(0);
    n_checks++; if (obs_n !== exp_n || obs_vec !== exp_vec) begin n_fail++; $display("FAIL mid_restart_frames: got %0d frames %h expected %0d frames %h", obs_n, obs_vec, exp_n, exp_vec); end
    n_checks++; if (obs_pos[0] !== 3)          begin n_fail++; $display("FAIL mid_restart_latency: got %0d expected 3", obs_pos[0]); end
  endtask

  task automatic test_start_ignored();
    fill_mem(8'h00); mem[0] = 8'h41; mem[1] = 8'h42;
    model();
    run_dump(1);
    n_checks++; if (obs_n !== exp_n || obs_vec !== exp_vec) begin n_fail++; $display("FAIL ign_frames: got %0d frames %h expected %0d frames %h", obs_n, obs_vec, exp_n, exp_vec); end
    n_checks++; if (obs_pos[0] !== 3 || gap_bad !== 0 || frame_err !== 0) begin n_fail++; $display("FAIL ign_timing: first %0d gap_bad %0d frame_err %0d expected 3 0 0", obs_pos[0], gap_bad, frame_err); end
    n_checks++; if (done_idx.size() !== 1)     begin n_fail++; $display("FAIL ign_done: pulses %0d expected 1", done_idx.size()); end
  endtask

  task automatic test_back_to_back();
    logic [127:0] exp2;
    fill_mem(8'h00); mem[0] = 8'h41;
    model();
    exp2 = exp_vec | (exp_vec << (8*exp_n));
    run_dump(2);
    n_checks++; if (obs_n !== 2*exp_n || obs_vec !== exp2) begin n_fail++; $display("FAIL b2b_frames: got %0d frames %h expected %0d frames %h", obs_n, obs_vec, 2*exp_n, exp2); end
    n_checks++; if (done_idx.size() !== 2)     begin n_fail++; $display("FAIL b2b_done: pulses %0d expected 2", done_idx.size()); end
    // DONE -> IDLE -> FETCH -> LOAD -> START_BIT after the first done pulse.
    n_checks++; if (done_idx.size() > 0 && obs_pos[exp_n] !== done_idx[0] + 4) begin n_fail++; $display("FAIL b2b_restart: second dump start bit at %0d expected %0d", obs_pos[exp_n], done_idx[0] + 4); end
    n_checks++; if (byte_count !== 9'd1 || ram_addr !== 8'd1) begin n_fail++; $display("FAIL b2b_final: count %0d addr %0d expected 1 1", byte_count, ram_addr); end
  endtask

  initial begin
    fill_mem(8'h00);
    test_reset();
    test_basic();
    test_empty();
    test_max_addr();
    test_delim_value();
    test_random();
    test_reset_midframe();
    test_start_ignored();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
